// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the mem_responder slice: FSM state enum,
// diagnostic state encodings and the request address error check.
`timescale 1ns/1ps
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] DIAG_IDLE = 2'd0;
  localparam logic [1:0] DIAG_WAIT = 2'd1;
  localparam logic [1:0] DIAG_RESP = 2'd2;

  localparam int unsigned WORD_LSB     = 2;
  localparam logic [1:0]  ALIGN_MASK   = 2'b11;
  localparam logic [7:0]  ERR_CNT_MAX  = 8'd255;

  // A request is in error when not word aligned or beyond the last stored word.
  function automatic logic addr_is_err(input logic [31:0] addr,
                                       input logic [31:0] depth_words);
    logic        misaligned;
    logic [31:0] word_idx;
    misaligned = ((addr[1:0] & ALIGN_MASK) != 2'b00);
    word_idx   = addr >> WORD_LSB;
    return misaligned || (word_idx >= depth_words);
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Word storage for mem_responder: synchronous byte-enabled write and a
// registered read port whose output register doubles as the response data.
`timescale 1ns/1ps
module mem_responder_array
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [3:0]    wr_strb,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic          rd_clr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem_r [DEPTH_WORDS];
  logic [31:0] rd_data_r;

  // Byte-lane write; the array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) begin
          mem_r[idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Read register: loads latch the word, otherwise cleared or held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_r <= 32'd0;
    end else if (rd_en) begin
      rd_data_r <= mem_r[idx];
    end else if (rd_clr) begin
      rd_data_r <= 32'd0;
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed wait states.
// Optional diagnostics (state_vector, error_count) with MEM_RESPONDER_DIAG_EN.
`timescale 1ns/1ps
module mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
`ifdef MEM_RESPONDER_DIAG_EN
  ,
  output logic [1:0]  state_vector,
  output logic [7:0]  error_count
`endif
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_LOAD  = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

  state_e      state_r, state_n;
  logic [3:0]  cnt_r, cnt_n;
  logic        write_r;
  logic [31:0] addr_r, wdata_r;
  logic [3:0]  wstrb_r;
  logic        req_ready_r, req_ready_n;
  logic        resp_valid_r, resp_valid_n;
  logic        resp_err_r, resp_err_n;

  logic        accept_s, enter_resp_s, hs_s, err_s;
  logic        cur_write_s;
  logic [31:0] cur_addr_s, cur_wdata_s;
  logic [3:0]  cur_wstrb_s;
  logic        arr_we_s, arr_re_s, arr_clr_s;

  assign accept_s     = req_valid && req_ready_r && (state_r == ST_IDLE);
  assign hs_s         = (state_r == ST_RESP) && resp_ready;
  assign enter_resp_s = (state_n == ST_RESP) && (state_r != ST_RESP);

  // Zero-latency requests reach RESP on the accept edge, so use live fields there.
  always_comb begin
    cur_write_s = write_r;
    cur_addr_s  = addr_r;
    cur_wdata_s = wdata_r;
    cur_wstrb_s = wstrb_r;
    if (state_r == ST_IDLE) begin
      cur_write_s = req_write;
      cur_addr_s  = req_addr;
      cur_wdata_s = req_wdata;
      cur_wstrb_s = req_wstrb;
    end else begin
      cur_write_s = write_r;
      cur_addr_s  = addr_r;
      cur_wdata_s = wdata_r;
      cur_wstrb_s = wstrb_r;
    end
  end

  assign err_s     = addr_is_err(cur_addr_s, DEPTH_LIM);
  assign arr_we_s  = enter_resp_s && cur_write_s && !err_s;
  assign arr_re_s  = enter_resp_s && !cur_write_s && !err_s;
  assign arr_clr_s = (enter_resp_s && !arr_re_s) || hs_s;

  mem_responder_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (arr_we_s),
    .wr_strb (cur_wstrb_s),
    .idx     (cur_addr_s[AW+1:WORD_LSB]),
    .wr_data (cur_wdata_s),
    .rd_en   (arr_re_s),
    .rd_clr  (arr_clr_s),
    .rd_data (resp_rdata)
  );

  // Request capture on the accept edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_r <= 1'b0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      wstrb_r <= 4'd0;
    end else if (accept_s) begin
      write_r <= req_write;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
      wstrb_r <= req_wstrb;
    end else begin
      write_r <= write_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      wstrb_r <= wstrb_r;
    end
  end

  // State and wait counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (LATENCY == 0) begin
            state_n = ST_RESP;
            cnt_n   = 4'd0;
          end else begin
            state_n = ST_WAIT;
            cnt_n   = LAT_LOAD;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_n = ST_RESP;
        end else begin
          cnt_n = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_RESP;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  // Next values of the registered handshake/status outputs.
  always_comb begin
    req_ready_n  = (state_n == ST_IDLE);
    resp_valid_n = (state_n == ST_RESP);
    if (enter_resp_s) begin
      resp_err_n = err_s;
    end else if (state_n == ST_RESP) begin
      resp_err_n = resp_err_r;
    end else begin
      resp_err_n = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
    end else begin
      req_ready_r  <= req_ready_n;
      resp_valid_r <= resp_valid_n;
      resp_err_r   <= resp_err_n;
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;

`ifdef MEM_RESPONDER_DIAG_EN
  logic [1:0] state_vector_r;
  logic [7:0] error_count_r;

  // Diagnostic state code and saturating count of errored handshakes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_vector_r <= DIAG_IDLE;
      error_count_r  <= 8'd0;
    end else begin
      case (state_n)
        ST_IDLE: state_vector_r <= DIAG_IDLE;
        ST_WAIT: state_vector_r <= DIAG_WAIT;
        ST_RESP: state_vector_r <= DIAG_RESP;
        default: state_vector_r <= DIAG_IDLE;
      endcase
      if (hs_s && resp_err_r && (error_count_r != ERR_CNT_MAX)) begin
        error_count_r <= error_count_r + 8'd1;
      end else begin
        error_count_r <= error_count_r;
      end
    end
  end

  assign state_vector = state_vector_r;
  assign error_count  = error_count_r;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (LATENCY=2 instance plus a LATENCY=0
// instance for back-to-back traffic) against a word-array reference model.
`timescale 1ns/1ps
module tb_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [3:0]  req_wstrb;
  logic        req_valid_b, req_ready_b, req_write_b, resp_valid_b, resp_ready_b, resp_err_b;
  logic [31:0] req_addr_b, req_wdata_b, resp_rdata_b;
  logic [3:0]  req_wstrb_b;
`ifdef MEM_RESPONDER_DIAG_EN
  logic [1:0]  state_vector, state_vector_b;
  logic [7:0]  error_count, error_count_b;
`endif

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
`ifdef MEM_RESPONDER_DIAG_EN
    , .state_vector(state_vector), .error_count(error_count)
`endif
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_write(req_write_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .req_wstrb(req_wstrb_b), .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
    .resp_rdata(resp_rdata_b), .resp_err(resp_err_b)
`ifdef MEM_RESPONDER_DIAG_EN
    , .state_vector(state_vector_b), .error_count(error_count_b)
`endif
  );

  int errors = 0;
  int checks = 0;
  int err_cnt_m = 0;
  logic [31:0] mem_m   [DEPTH];
  logic [31:0] mem_b_m [DEPTH];

  // Reference: word array updated per byte lane; errors leave it untouched.
  function automatic void model(input logic wr, input logic [31:0] addr, wdata,
                                input logic [3:0] strb,
                                output logic [31:0] rdata, output logic err);
    int w;
    err   = (addr % 4 != 0) || ((addr / 4) >= DEPTH);
    rdata = 32'd0;
    if (!err) begin
      w = int'(addr / 4);
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (strb[i]) mem_m[w][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        rdata = mem_m[w];
      end
    end
  endfunction

  // Drive one request on dut, hold the response for 'hold' cycles, then handshake.
  task automatic do_txn(input logic wr, input logic [31:0] addr, wdata,
                        input logic [3:0] strb, input int hold,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output bit stable);
    int w;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    rdata = resp_rdata; err = resp_err; stable = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!resp_valid || resp_rdata !== rdata || resp_err !== err || req_ready) stable = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    if (resp_valid) stable = 1'b0;
    if (err) err_cnt_m++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", resp_err); end
`ifdef MEM_RESPONDER_DIAG_EN
    checks++; if (state_vector !== 2'd0) begin errors++; $display("FAIL reset_state_vector got=%0d exp=0", state_vector); end
`endif
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] rd, erd; logic er, eer; int lat; bit st;
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, st);
    model(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, eer);
    checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL basic_store got err=%b data=%h exp err=0 data=0", er, rd); end
    checks++; if (lat != LAT + 1) begin errors++; $display("FAIL basic_store_latency got=%0d exp=%0d", lat, LAT + 1); end
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, st);
    model(1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL basic_load got=%h err=%b exp=deadbeef err=0", rd, er); end
    checks++; if (lat != LAT + 1) begin errors++; $display("FAIL basic_load_latency got=%0d exp=%0d", lat, LAT + 1); end
  endtask

  task automatic test_strobe();
    logic [31:0] rd, erd; logic er, eer; int lat; bit st;
    do_txn(1'b1, 32'h10, 32'h11223344, 4'h2, 0, rd, er, lat, st);
    model(1'b1, 32'h10, 32'h11223344, 4'h2, erd, eer);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, st);
    checks++; if (rd !== 32'hDEAD33EF) begin errors++; $display("FAIL strobe_lane1 got=%h exp=dead33ef", rd); end
    do_txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, rd, er, lat, st);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL strobe_zero_err got=%b exp=0", er); end
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, st);
    model(1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
    checks++; if (rd !== erd) begin errors++; $display("FAIL strobe_zero_unchanged got=%h exp=%h", rd, erd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic er, eer; int lat; bit st;
    do_txn(1'b0, 32'h13, 32'h0, 4'h0, 0, rd, er, lat, st);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL err_misaligned got err=%b data=%h exp err=1 data=0", er, rd); end
    checks++; if (lat != LAT + 1) begin errors++; $display("FAIL err_latency got=%0d exp=%0d", lat, LAT + 1); end
    do_txn(1'b0, 32'h1000, 32'h0, 4'h0, 0, rd, er, lat, st);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL err_range got err=%b data=%h exp err=1 data=0", er, rd); end
`ifdef MEM_RESPONDER_DIAG_EN
    checks++; if (error_count !== 8'd2) begin errors++; $display("FAIL err_count got=%0d exp=2", error_count); end
`endif
    do_txn(1'b1, 32'h11, 32'h55555555, 4'hF, 0, rd, er, lat, st);
    do_txn(1'b1, 32'h1010, 32'h55555555, 4'hF, 0, rd, er, lat, st);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_store_range got=%b exp=1", er); end
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, st);
    model(1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
    checks++; if (rd !== erd) begin errors++; $display("FAIL err_mem_untouched got=%h exp=%h", rd, erd); end
`ifdef MEM_RESPONDER_DIAG_EN
    checks++; if (error_count !== 8'(err_cnt_m)) begin errors++; $display("FAIL err_count_total got=%0d exp=%0d", error_count, err_cnt_m); end
`endif
  endtask

  task automatic test_hold();
    logic [31:0] rd, erd, erd2, cap; logic er, eer, cap_e; int lat, w; bit st;
    do_txn(1'b1, 32'h14, 32'hA5A5F00D, 4'hF, 0, rd, er, lat, st);
    model(1'b1, 32'h14, 32'hA5A5F00D, 4'hF, erd, eer);
    model(1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
    model(1'b0, 32'h14, 32'h0, 4'h0, erd2, eer);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wstrb = 4'h0;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    req_addr = 32'h14;
    lat = 1;
    while (!resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    cap = resp_rdata; cap_e = resp_err;
    checks++; if (cap !== erd) begin errors++; $display("FAIL hold_first_data got=%h exp=%h", cap, erd); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (!resp_valid || resp_rdata !== cap || resp_err !== cap_e || req_ready !== 1'b0) begin
        errors++; $display("FAIL hold_stable cycle=%0d got valid=%b data=%h ready=%b exp valid=1 data=%h ready=0",
                            c, resp_valid, resp_rdata, req_ready, cap);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL hold_handshake got valid=%b ready=%b exp valid=0 ready=1", resp_valid, req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_second_accept got ready=%b exp=0", req_ready); end
    lat = 1;
    while (!resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != LAT + 1 || resp_rdata !== erd2) begin errors++; $display("FAIL hold_second_resp got lat=%0d data=%h exp lat=%0d data=%h", lat, resp_rdata, LAT + 1, erd2); end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; logic er, eer; int lat, w; bit st;
    do_txn(1'b1, 32'h20, 32'h0, 4'hF, 0, rd, er, lat, st);
    model(1'b1, 32'h20, 32'h0, 4'hF, erd, eer);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got ready=%b valid=%b data=%h err=%b exp all 0", req_ready, resp_valid, resp_rdata, resp_err);
    end
    @(negedge clk);
    rst = 1'b1;
    err_cnt_m = 0;
    repeat (2) @(negedge clk);
`ifdef MEM_RESPONDER_DIAG_EN
    checks++; if (error_count !== 8'd0) begin errors++; $display("FAIL midreset_err_count got=%0d exp=0", error_count); end
`endif
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, st);
    model(1'b0, 32'h20, 32'h0, 4'h0, erd, eer);
    checks++; if (rd !== 32'h0 || rd !== erd) begin errors++; $display("FAIL midreset_store_aborted got=%h exp=%h", rd, erd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, d; logic er, eer, wr; logic [3:0] s; int lat, r; bit st;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      do_txn(1'b1, 32'(4 * i), d, 4'hF, 0, rd, er, lat, st);
      model(1'b1, 32'(4 * i), d, 4'hF, erd, eer);
    end
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom); d = $urandom; s = 4'($urandom); r = int'($urandom_range(0, 9));
      if (r == 0)      a = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
      else if (r == 1) a = 32'h1000 + 32'(4 * $urandom_range(0, 1000));
      else             a = 32'(4 * $urandom_range(0, 15));
      do_txn(wr, a, d, s, int'($urandom_range(0, 3)), rd, er, lat, st);
      model(wr, a, d, s, erd, eer);
      checks++;
      if (rd !== erd || er !== eer || lat != LAT + 1 || !st) begin
        errors++; $display("FAIL random_txn i=%0d wr=%b addr=%h got data=%h err=%b lat=%0d stable=%0d exp data=%h err=%b lat=%0d",
                           i, wr, a, rd, er, lat, st, erd, eer, LAT + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [$];
    logic [31:0] ex;
    int words [8];
    int sent, got, last, cyc;
    bit acc;
    for (int i = 0; i < 8; i++) words[i] = int'($urandom_range(0, 63));
    for (int ph = 0; ph < 2; ph++) begin
      sent = 0; got = 0; last = -1; cyc = 0;
      exp_q.delete();
      @(negedge clk);
      resp_ready_b = 1'b1; req_valid_b = 1'b1; req_write_b = (ph == 0); req_wstrb_b = 4'hF;
      req_addr_b = 32'(4 * words[0]); req_wdata_b = $urandom;
      while (got < 8 && cyc < 100) begin
        if (resp_valid_b) begin
          ex = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0BAD0;
          got++;
          checks++; if (resp_rdata_b !== ex || resp_err_b !== 1'b0) begin errors++; $display("FAIL b2b_data ph=%0d got=%h err=%b exp=%h err=0", ph, resp_rdata_b, resp_err_b, ex); end
          if (last >= 0) begin
            checks++; if (cyc - last != 2) begin errors++; $display("FAIL b2b_spacing ph=%0d got=%0d exp=2", ph, cyc - last); end
          end
          last = cyc;
        end
        acc = req_ready_b && req_valid_b;
        if (acc) begin
          if (ph == 0) begin
            mem_b_m[req_addr_b / 4] = req_wdata_b;
            exp_q.push_back(32'd0);
          end else begin
            exp_q.push_back(mem_b_m[req_addr_b / 4]);
          end
          sent++;
        end
        @(posedge clk); #1;
        if (acc) begin
          if (sent >= 8) req_valid_b = 1'b0;
          else begin req_addr_b = 32'(4 * words[sent]); req_wdata_b = $urandom; end
        end
        @(negedge clk);
        cyc++;
      end
      checks++; if (got != 8) begin errors++; $display("FAIL b2b_count ph=%0d got=%0d exp=8", ph, got); end
      req_valid_b = 1'b0; resp_ready_b = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_wstrb = 4'd0; resp_ready = 1'b0;
    req_valid_b = 1'b0; req_write_b = 1'b0; req_addr_b = 32'd0; req_wdata_b = 32'd0; req_wstrb_b = 4'd0; resp_ready_b = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic();
    test_strobe();
    test_errors();
    test_hold();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the number of 32-bit words stored (power of two, 16..65536).
REQ-002 Parameter LATENCY, default 2, SHALL set the wait states between request accept and response (0..15).
REQ-003 clk  input  1  single clock for the block; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 req_valid  input  1  requester (controller) presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load/fetch.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_wstrb  input  4  store byte enables; bit i enables byte lane i.
REQ-011 resp_valid  output  1  response presented.
REQ-012 resp_ready  input  1  requester accepts the response.
REQ-013 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 resp_err  output  1  request was misaligned or out of range.

Function
REQ-015 The FSM SHALL have the states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE with rst deasserted.
REQ-016 A request SHALL be accepted on a cycle where req_valid and req_ready are both 1; req_write, req_addr, req_wdata and req_wstrb SHALL be captured on that edge.
REQ-017 On accept with LATENCY=0 the FSM SHALL go IDLE->RESP; otherwise it SHALL go IDLE->WAIT with the wait counter loaded to LATENCY-1.
REQ-018 In WAIT the counter SHALL decrement each cycle; at 0 the FSM SHALL go to RESP, so resp_valid rises exactly LATENCY+1 cycles after the accept edge.
REQ-019 The memory access SHALL occur on the edge entering RESP: loads latch the addressed word into resp_rdata; stores update only lanes with req_wstrb set.
REQ-020 An error SHALL be flagged when req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH_WORDS; memory SHALL remain unchanged, resp_err=1, resp_rdata=0, and latency SHALL be unchanged.
REQ-021 A store with req_wstrb=0 SHALL complete without error and without modifying memory.
REQ-022 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until resp_ready=1; on that edge the FSM SHALL return to IDLE and resp_valid SHALL fall.
REQ-023 No request SHALL be accepted in WAIT or RESP; the earliest next accept is the cycle after the response handshake (one outstanding request maximum).
REQ-024 req_valid and request fields SHALL be ignored outside IDLE.

Reset
REQ-025 While rst=0: state IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, wait counter 0.
REQ-026 Reset asserted mid-request SHALL abort it; a store not yet at the RESP edge SHALL NOT be written.
REQ-027 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro MEM_RESPONDER_DIAG_EN defined: outputs state_vector (2 bits: IDLE=0, WAIT=1, RESP=2) and error_count (8 bits, saturating at 255, +1 per errored response handshake, reset to 0) SHALL exist.
REQ-029 Macro undefined: those ports and the counter SHALL be absent; all other behaviour identical.

Structure
REQ-030 Package riscv_mem_pkg SHALL hold the state enum, diagnostic state encodings and the error-check helper constants.
REQ-031 Storage SHALL be the sub-module mem_responder_array (synchronous write with byte enables, synchronous read).

Verification
REQ-032 LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, wstrb 0xF; then load 0x10 -> resp_rdata 0xDEADBEEF, resp_err=0, resp_valid 3 cycles after each accept.
REQ-033 Store 0x10 wdata 0x11223344 wstrb 0x2 over 0xDEADBEEF -> load returns 0xDEAD33EF.
REQ-034 Load 0x13 and load 0x1000 with DEPTH_WORDS=1024 -> resp_err=1, resp_rdata=0; diag build error_count=2.
REQ-035 Hold resp_ready=0 for 5 cycles in RESP with req_valid=1 -> response stable, req_ready=0, no second accept until the cycle after the handshake.
REQ-036 Assert rst during WAIT of store to 0x20 (prior 0x0) -> outputs at reset values; later load 0x20 returns 0x0.
REQ-037 LATENCY=0: back-to-back loads with resp_ready=1 -> one response every 2 cycles.
